// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter and its coefficient loader.
package fir_pkg;

    // Default sizes shared with the FIR datapath.
    localparam int FIR_FILTER_LENGTH     = 8;
    localparam int FIR_COEFFICIENT_WIDTH = 16;

    // Coefficient loader states: assembling a frame, discarding an
    // over-long frame, and holding a complete frame awaiting commit.
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        FULL  = 2'd2
    } coef_ld_state_t;

    // Width of a tap index; never less than one bit so a single-tap
    // filter still has a legal counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// Serial coefficient loader: collects one tap set from a valid/ready
// stream into a shadow bank, checks the frame length, and swaps the
// shadow bank into the active bank atomically on a commit pulse so the
// filter never sees a half-written tap set.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int FILTER_LENGTH     = FIR_FILTER_LENGTH,
    parameter int COEFFICIENT_WIDTH = FIR_COEFFICIENT_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic signed [COEFFICIENT_WIDTH-1:0] s_coef,
    input  logic                                s_last,
    input  logic                                commit,
    output logic signed [COEFFICIENT_WIDTH-1:0] coefficients [FILTER_LENGTH],
    output logic                                loaded,
    output logic                                frame_err
);

    localparam int IDX_W = idx_width(FILTER_LENGTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FILTER_LENGTH - 1);

    coef_ld_state_t state;
    logic [IDX_W-1:0] idx;
    logic signed [COEFFICIENT_WIDTH-1:0] shadow [FILTER_LENGTH];

    logic beatInLoad;
    logic atLastTap;

    assign s_ready    = (state != FULL);
    assign loaded     = (state == FULL);
    assign beatInLoad = (state == LOAD) && s_valid;
    assign atLastTap  = (idx == IDX_LAST);

    // Frame sequencing: advance the tap index per beat and decide where a
    // frame ends up (complete, short, or long) when it finishes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
            idx   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (s_valid) begin
                        if (s_last || atLastTap) begin
                            idx <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                        if (atLastTap) begin
                            state <= s_last ? FULL : DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (s_valid && s_last) begin
                        state <= LOAD;
                    end
                end
                FULL: begin
                    if (commit) begin
                        state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // A frame is malformed exactly when s_last disagrees with being on the
    // final tap: early s_last is a short frame, missing s_last a long one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= beatInLoad && (atLastTap != s_last);
        end
    end

    // Shadow bank: each accepted beat lands at its tap position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FILTER_LENGTH; i++) begin
                shadow[i] <= '0;
            end
        end else if (beatInLoad) begin
            shadow[idx] <= s_coef;
        end
    end

    // Active bank: replaced as a whole only by a commit while a complete
    // frame is waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FILTER_LENGTH; i++) begin
                coefficients[i] <= '0;
            end
        end else if ((state == FULL) && commit) begin
            for (int i = 0; i < FILTER_LENGTH; i++) begin
                coefficients[i] <= shadow[i];
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Testbench for fir_coeff_loader: directed scenarios followed by random
// traffic, all compared against a frame-level reference model.
module tb_fir_coeff_loader;

    localparam int L = 4;
    localparam int W = 16;

    logic clk;
    logic rst;
    logic s_valid;
    logic s_ready;
    logic signed [W-1:0] s_coef;
    logic s_last;
    logic commit;
    logic signed [W-1:0] coefs [L];
    logic loaded;
    logic frame_err;

    int checkCount;
    int passCount;
    int failCount;

    // Reference model state: the frame being collected, whether we are
    // throwing away an over-long frame, a complete frame awaiting commit,
    // and the tap set the filter currently sees.
    logic signed [W-1:0] frameQ [$];
    bit discarding;
    bit pending;
    logic signed [W-1:0] pendFrame [L];
    logic signed [W-1:0] expActive [L];
    bit expErr;

    fir_coeff_loader #(
        .FILTER_LENGTH(L),
        .COEFFICIENT_WIDTH(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_coef(s_coef),
        .s_last(s_last),
        .commit(commit),
        .coefficients(coefs),
        .loaded(loaded),
        .frame_err(frame_err)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        frameQ.delete();
        discarding = 0;
        pending    = 0;
        expErr     = 0;
        for (int i = 0; i < L; i++) begin
            pendFrame[i] = '0;
            expActive[i] = '0;
        end
    endtask

    // One clock edge of the model, given the inputs presented at that edge.
    task automatic modelStep(input bit v, input logic signed [W-1:0] c,
                             input bit last, input bit cm);
        expErr = 0;
        if (pending) begin
            if (cm) begin
                for (int i = 0; i < L; i++) expActive[i] = pendFrame[i];
                pending = 0;
            end
        end else if (v) begin
            if (discarding) begin
                if (last) discarding = 0;
            end else begin
                frameQ.push_back(c);
                if (frameQ.size() == L) begin
                    if (last) begin
                        for (int i = 0; i < L; i++) pendFrame[i] = frameQ[i];
                        pending = 1;
                    end else begin
                        expErr     = 1;
                        discarding = 1;
                    end
                    frameQ.delete();
                end else if (last) begin
                    expErr = 1;
                    frameQ.delete();
                end
            end
        end
    endtask

    task automatic checkVal(input string tag, input logic [W-1:0] obs,
                            input logic [W-1:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string step);
        checkVal({step, " loaded"}, W'(loaded), W'(pending));
        checkVal({step, " s_ready"}, W'(s_ready), W'(!pending));
        checkVal({step, " frame_err"}, W'(frame_err), W'(expErr));
        for (int i = 0; i < L; i++) begin
            checkVal($sformatf("%s coef[%0d]", step, i), coefs[i], expActive[i]);
        end
    endtask

    // Drive one cycle of inputs (we sit just after a falling edge), let the
    // DUT and model see the rising edge, then check on the next falling edge.
    task automatic applyStimulus(input string step, input bit v,
                                 input int c, input bit last, input bit cm);
        s_valid = v;
        s_coef  = W'(c);
        s_last  = last;
        commit  = cm;
        @(posedge clk);
        modelStep(v, W'(c), last, cm);
        @(negedge clk);
        checkOutput(step);
    endtask

    task automatic sendFrame(input string step, input int a, input int b,
                             input int c, input int d, input bit lastOnEnd);
        applyStimulus(step, 1, a, 0, 0);
        applyStimulus(step, 1, b, 0, 0);
        applyStimulus(step, 1, c, 0, 0);
        applyStimulus(step, 1, d, lastOnEnd, 0);
    endtask

    initial begin
        int cnt;
        bit v, last, cm;
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        s_valid = 0;
        s_coef  = '0;
        s_last  = 0;
        commit  = 0;
        rst     = 0;
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        checkOutput("reset");

        // Normal frame, then commit.
        sendFrame("normal", 1, 2, 3, 4, 1);
        applyStimulus("hold_full", 0, 0, 0, 0);
        applyStimulus("commit1", 0, 0, 0, 1);

        // Short frame, then a boundary-value frame.
        applyStimulus("short", 1, 5, 0, 0);
        applyStimulus("short", 1, 6, 1, 0);
        applyStimulus("after_short", 0, 0, 0, 0);
        sendFrame("extremes", -32768, 7, 8, 32767, 1);
        applyStimulus("commit2", 0, 0, 0, 1);

        // Long frame, drained tail, then a good frame.
        sendFrame("long", 1, 2, 3, 4, 0);
        applyStimulus("drain", 1, 9, 0, 0);
        applyStimulus("drain", 1, 10, 1, 0);
        sendFrame("after_long", 11, 12, 13, 14, 1);
        applyStimulus("commit3", 0, 0, 0, 1);

        // Commit while loading is ignored, commit on last beat is ignored.
        applyStimulus("ign_commit", 0, 0, 0, 1);
        applyStimulus("ign_commit", 1, 21, 0, 1);
        applyStimulus("ign_commit", 1, 22, 0, 0);
        applyStimulus("ign_commit", 1, 23, 0, 0);
        applyStimulus("commit_with_last", 1, 24, 1, 1);

        // Backpressure in FULL, then commit held for several cycles while
        // the stalled beat waits; it becomes beat 0 of the next frame.
        repeat (5) applyStimulus("backpressure", 1, 99, 0, 0);
        applyStimulus("commit4", 1, 99, 0, 1);
        applyStimulus("beat0_99", 1, 99, 0, 1);
        applyStimulus("next", 1, 98, 0, 1);
        applyStimulus("next", 1, 97, 0, 0);
        applyStimulus("next", 1, 96, 1, 0);
        applyStimulus("commit5", 0, 0, 0, 1);
        applyStimulus("commit_held", 0, 0, 0, 1);

        // Reset in the middle of a frame.
        applyStimulus("midframe", 1, 1, 0, 0);
        applyStimulus("midframe", 1, 2, 0, 0);
        s_valid = 0;
        rst = 0;
        modelReset();
        #1;
        checkOutput("in_reset");
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        sendFrame("post_reset", 5, 6, 7, 8, 1);
        applyStimulus("commit6", 0, 0, 0, 1);

        // Random traffic, biased toward well-formed frames.
        cnt = 0;
        for (int n = 0; n < 500; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            cm = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) < 8) last = (cnt == L - 1);
            else last = $urandom_range(0, 1);
            if (v && !pending) cnt = last ? 0 : (cnt + 1) % L;
            applyStimulus("random", v, int'($urandom_range(0, 65535)), last, cm);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
